bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 din  input  WIDTH  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word offered for transfer.
REQ-006 din_ready  output  1  block accepts din on this edge.
REQ-007 stall  input  1  freeze serial output; hold current bit and state.
REQ-008 x  output  1  serial bit stream; drives the x input of the downstream sequence detector.
REQ-009 x_valid  output  1  x carries a payload bit this cycle.
REQ-010 busy  output  1  a word is being shifted out.

Function
REQ-011 The block SHALL implement two states: IDLE and SHIFT.
REQ-012 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din is captured into an internal WIDTH-bit shift register.
REQ-013 din_ready SHALL be combinational: 1 in IDLE; in SHIFT, 1 only when bit counter = WIDTH-1 and stall=0; 0 otherwise.
REQ-014 IDLE -> SHIFT on transfer; bit counter SHALL load 0.
REQ-015 Latency: first bit of a word SHALL appear on x, with x_valid=1, in the cycle immediately after the transfer edge.
REQ-016 In SHIFT with stall=0, each edge SHALL advance one bit and increment the counter; each bit is presented for exactly one cycle.
REQ-017 In SHIFT with stall=1, x, x_valid, counter and shift register SHALL hold; din_ready=0.
REQ-018 On the last bit (counter = WIDTH-1, stall=0): with a transfer, SHALL reload and stay in SHIFT with counter 0 (no gap cycle); without one, SHALL return to IDLE.
REQ-019 In IDLE, x SHALL be 0 and x_valid SHALL be 0; stall has no effect in IDLE.
REQ-020 busy SHALL equal 1 exactly when state is SHIFT.
REQ-021 x, x_valid and busy SHALL be registered outputs (no combinational path from inputs).
REQ-022 din SHALL be sampled only on a transfer edge; changes at other times SHALL not affect the output.
REQ-023 Counter width SHALL be ceil(log2(WIDTH)); counter SHALL never exceed WIDTH-1.

Reset
REQ-024 rst=0 SHALL immediately, without a clock edge, force IDLE, counter=0, shift register=0, x=0, x_valid=0, busy=0.
REQ-025 Reset asserted mid-word SHALL discard the remaining bits; no partial word SHALL resume after reset.
REQ-026 While rst=0, din_ready SHALL be 0 and no transfer SHALL occur.
REQ-027 After rst deassertion, the first transfer SHALL be accepted on the first rising edge with din_valid=1.

Configuration
REQ-028 Macro SER_LSB_FIRST_EN: when defined, bits SHALL be emitted LSB first (din[0] first).
REQ-029 When SER_LSB_FIRST_EN is undefined, bits SHALL be emitted MSB first (din[WIDTH-1] first); this is the default build.
REQ-030 Handshake, latency, stall and reset behaviour SHALL be identical in both builds.

Verification
REQ-031 WIDTH=8, MSB-first: transfer 8'b1010_1010, stall=0 -> x = 1,0,1,0,1,0,1,0 on 8 consecutive cycles with x_valid=1, then x_valid=0, busy=0.
REQ-032 Back-to-back: 8'hA5 then 8'h0F, din_valid held 1 -> 16 contiguous x_valid cycles, x = 10100101 00001111, din_ready=1 only in cycles 0 and 8.
REQ-033 Stall: transfer 8'hC3, assert stall for 3 cycles after the 2nd bit -> x holds 1 for 4 cycles total, remaining bits 000011 follow, total 11 busy cycles.
REQ-034 Reset mid-word: transfer 8'hFF, drive rst=0 after 4 bits, between edges -> x=0, x_valid=0, busy=0 immediately; after release, x_valid stays 0 until next transfer.
REQ-035 SER_LSB_FIRST_EN defined: transfer 8'h01 -> x = 1,0,0,0,0,0,0,0.
REQ-036 Idle hold-off: din_valid=0 for 10 cycles after reset -> x=0, x_valid=0, din_ready=1 throughout.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with valid/ready intake and stall; feeds a downstream sequence detector.
// Bit order: MSB first by default, LSB first when SER_LSB_FIRST_EN is defined.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             x_nxt, x_valid_nxt, busy_nxt;

  logic             last_bit;
  logic             xfer;
  logic             load_bit, next_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  // x always holds the bit in flight; shreg keeps only the bits still to come
`ifdef SER_LSB_FIRST_EN
  assign load_bit   = din[0];
  assign load_rest  = din >> 1;
  assign next_bit   = shreg[0];
  assign shift_rest = shreg >> 1;
`else
  assign load_bit   = din[WIDTH-1];
  assign load_rest  = din << 1;
  assign next_bit   = shreg[WIDTH-1];
  assign shift_rest = shreg << 1;
`endif

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign din_ready = rst & ((state == IDLE) | (last_bit & ~stall));
  assign xfer      = din_valid & din_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    x_nxt       = x;
    x_valid_nxt = x_valid;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
          shreg_nxt   = load_rest;
          x_nxt       = load_bit;
          x_valid_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (!last_bit) begin
            cnt_nxt   = cnt + CW'(1);
            shreg_nxt = shift_rest;
            x_nxt     = next_bit;
          end else if (xfer) begin
            cnt_nxt     = '0;
            shreg_nxt   = load_rest;
            x_nxt       = load_bit;
            x_valid_nxt = 1'b1;
          end else begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            shreg_nxt   = '0;
            x_nxt       = 1'b0;
            x_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        shreg_nxt   = '0;
        x_nxt       = 1'b0;
        x_valid_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == SHIFT);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: directed scenarios plus random traffic, checked against a
// queue-of-pending-bits reference model.
module tb_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         stall;
  logic         x;
  logic         x_valid;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference: bits still owed to the stream; front element is the bit on x now
  bit q[$];

  // Observed-stream bookkeeping for the directed scenarios
  logic [31:0] cap;
  int          nbusy;
  int          nready;

  bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .stall     (stall),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return rst && (q.size() == 0 || (q.size() == 1 && !stall));
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < int'(W); i++) begin
`ifdef SER_LSB_FIRST_EN
      q.push_back(d[i]);
`else
      q.push_back(d[W-1-i]);
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".din_ready"}, 32'(din_ready), 32'(model_ready()));
    chk({tag, ".x"},         32'(x),         (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".x_valid"},   32'(x_valid),   32'(q.size() > 0));
    chk({tag, ".busy"},      32'(busy),      32'(q.size() > 0));
  endtask

  // One clock: inputs are already set (after a negedge); check, then advance the model on the edge
  task automatic step(input string tag);
    bit rdy, xf;
    #1;
    check_outputs(tag);
    if (x_valid === 1'b1) cap = {cap[30:0], x};
    if (busy === 1'b1) nbusy++;
    if (din_ready === 1'b1) nready++;
    rdy = model_ready();
    xf  = rdy && din_valid;
    @(posedge clk);
    if (!rst) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !stall) void'(q.pop_front());
      if (xf) push_word(din);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset between edges: outputs must clear at once
  task automatic reset_now(input string tag);
    rst = 1'b0;
    #1;
    q.delete();
    chk({tag, ".x"},         32'(x),         32'd0);
    chk({tag, ".x_valid"},   32'(x_valid),   32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".din_ready"}, 32'(din_ready), 32'd0);
  endtask

  task automatic clear_obs();
    cap = '0; nbusy = 0; nready = 0;
  endtask

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; stall = 1'b0;
    clear_obs();
    #1;
    chk("por.x", 32'(x), 32'd0);
    chk("por.x_valid", 32'(x_valid), 32'd0);
    chk("por.busy", 32'(busy), 32'd0);
    chk("por.din_ready", 32'(din_ready), 32'd0);
    @(negedge clk);
    din_valid = 1'b1; din = 8'h5A;
    step("in_reset");
    step("in_reset");
    rst = 1'b1; din_valid = 1'b0;

    // Idle hold-off
    for (int i = 0; i < 10; i++) begin
      stall = (i % 3 == 0);
      step("idle");
    end
    stall = 1'b0;

    // Single word 8'hAA
    clear_obs();
    din = 8'hAA; din_valid = 1'b1;
    step("aa");
    din_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 10; i++) step("aa");
`ifdef SER_LSB_FIRST_EN
    chk("aa.stream", cap & 32'hFF, 32'h55);
`else
    chk("aa.stream", cap & 32'hFF, 32'hAA);
`endif
    chk("aa.busy_cycles", 32'(nbusy), 32'd8);

    // Back-to-back A5, 0F
    clear_obs();
    din = 8'hA5; din_valid = 1'b1;
    step("b2b");
    for (int i = 1; i < 16; i++) begin
      if (i == 8) din = 8'h0F;
      else din = 8'(i * 37);
      step("b2b");
    end
    chk("b2b.ready_cycles", 32'(nready), 32'd2);
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("b2b");
`ifdef SER_LSB_FIRST_EN
    chk("b2b.stream", cap & 32'hFFFF, 32'hA5F0);
`else
    chk("b2b.stream", cap & 32'hFFFF, 32'hA50F);
`endif

    // Stall after the second bit of C3
    clear_obs();
    din = 8'hC3; din_valid = 1'b1;
    step("stall");
    din_valid = 1'b0; din = 8'hFF;
    step("stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 1'b0;
    for (int i = 0; i < 8; i++) step("stall");
    chk("stall.busy_cycles", 32'(nbusy), 32'd11);

    // Reset mid-word
    din = 8'hFF; din_valid = 1'b1;
    step("rstmid");
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("rstmid");
    reset_now("rstmid.async");
    din_valid = 1'b1;
    step("rstmid.held");
    rst = 1'b1; din_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("rstmid.after");
    din = 8'h3C; din_valid = 1'b1;
    step("rstmid.first");
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) step("rstmid.first");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 99) == 0) begin
        reset_now("rand.async");
        step("rand.rst");
        rst = 1'b1;
      end else begin
        step("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
